// File: rtl/roi_readout_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : roi_readout_seq_pkg
// Desc     : Shared state encodings, default parameters and config check for
//            the ROI readout sequencer.
// Revision : 1.0  initial release
// ============================================================================
package roi_readout_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH1  = 2'd1,
        ST_PH2  = 2'd2,
        ST_MUX  = 2'd3
    } state_t;

    localparam int C_DEF_NUM_ROWS  = 160;
    localparam int C_DEF_NUM_MUX   = 46;
    localparam int C_DEF_ROW_W     = 8;
    localparam int C_DEF_MUX_W     = 6;
    localparam int C_DEF_PHI1_CNT  = 9;
    localparam int C_DEF_PRECH_CNT = 1;
    localparam int C_DEF_PHI2_CNT  = 9;
    localparam int C_DEF_TLAT      = 24;

    localparam int C_STEP_W = 4;

    // All operands widened to 32 bits so the bounds compare cleanly
    // regardless of the address widths chosen at instantiation.
    function automatic logic cfg_ok(
        input logic [31:0] row_start,
        input logic [31:0] row_end,
        input logic [31:0] row_step,
        input logic [31:0] mux_start,
        input logic [31:0] mux_end,
        input logic [31:0] num_rows,
        input logic [31:0] num_mux
    );
        return (row_start <= row_end) && (row_end < num_rows) &&
               (mux_start <= mux_end) && (mux_end < num_mux) &&
               (row_step != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/roi_dv_delay.sv
`default_nettype none
// ============================================================================
// Module   : roi_dv_delay
// Desc     : C_DEPTH-deep data-valid shift register with synchronous flush
//            and a registered "contents nonzero" flag.
// Revision : 1.0  initial release
// ============================================================================
module roi_dv_delay #(
    parameter int C_DEPTH = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_din,
    output logic o_dout,
    output logic o_nonzero
);

    logic [C_DEPTH-1:0] r_sr;
    logic [C_DEPTH-1:0] w_sr_nxt;
    logic               r_nz;

    generate
        if (C_DEPTH == 1) begin : g_single
            assign w_sr_nxt = i_flush ? 1'b0 : i_din;
        end else begin : g_multi
            assign w_sr_nxt = i_flush ? '0 : {r_sr[C_DEPTH-2:0], i_din};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
            r_nz <= 1'b0;
        end else begin
            r_sr <= w_sr_nxt;
            r_nz <= |w_sr_nxt;
        end
    end

    assign o_dout    = r_sr[C_DEPTH-1];
    assign o_nonzero = r_nz;

endmodule
`default_nettype wire

// File: rtl/roi_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : roi_readout_seq
// Desc     : ROI readout sequencer: row strobes, row/mux addressing and an
//            ADC-latency-aligned data-valid, with start/busy/done and abort.
// Revision : 1.0  initial release
// ============================================================================
module roi_readout_seq
    import roi_readout_seq_pkg::*;
#(
    parameter int C_NUM_ROWS  = C_DEF_NUM_ROWS,
    parameter int C_NUM_MUX   = C_DEF_NUM_MUX,
    parameter int C_ROW_W     = C_DEF_ROW_W,
    parameter int C_MUX_W     = C_DEF_MUX_W,
    parameter int C_PHI1_CNT  = C_DEF_PHI1_CNT,
    parameter int C_PRECH_CNT = C_DEF_PRECH_CNT,
    parameter int C_PHI2_CNT  = C_DEF_PHI2_CNT,
    parameter int C_TLAT      = C_DEF_TLAT
) (
    input  logic                ADC_PIXCLK,
    input  logic                RESETN,
    input  logic                START,
    input  logic                CONTINUOUS,
    input  logic                ABORT,
    input  logic [C_ROW_W-1:0]  ROW_START,
    input  logic [C_ROW_W-1:0]  ROW_END,
    input  logic [C_STEP_W-1:0] ROW_STEP,
    input  logic [C_MUX_W-1:0]  MUX_START,
    input  logic [C_MUX_W-1:0]  MUX_END,
    output logic                PHI1,
    output logic                PRECH_COL,
    output logic                PIXRES,
    output logic [C_ROW_W-1:0]  ROW_ADD,
    output logic [C_MUX_W-1:0]  MUX_ADD,
    output logic                PRECHN_AMP,
    output logic                DATA_VALID,
    output logic                BUSY,
    output logic                FRAME_DONE,
    output logic                CFG_ERR,
    output logic [15:0]         FRAME_CNT
);

    localparam int C_CNT_MAX = (C_PHI1_CNT > C_PHI2_CNT) ? C_PHI1_CNT : C_PHI2_CNT;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_PH1_LAST = C_CNT_W'(C_PHI1_CNT - 1);
    localparam logic [C_CNT_W-1:0] C_PH2_LAST = C_CNT_W'(C_PHI2_CNT - 1);
    localparam logic [C_CNT_W-1:0] C_PRECH_N  = C_CNT_W'(C_PRECH_CNT);
    localparam logic [C_ROW_W-1:0] C_ROW_PARK = C_ROW_W'(C_NUM_ROWS);
    localparam logic [C_MUX_W-1:0] C_MUX_PARK = C_MUX_W'(C_NUM_MUX);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [C_CNT_W-1:0]    r_cnt;
    logic [C_CNT_W-1:0]    w_cnt_nxt;
    logic [C_ROW_W-1:0]    r_row;
    logic [C_ROW_W-1:0]    w_row_nxt;
    logic [C_MUX_W-1:0]    r_mux;
    logic [C_MUX_W-1:0]    w_mux_nxt;

    logic [C_ROW_W-1:0]    r_row_end;
    logic [C_STEP_W-1:0]   r_step;
    logic [C_MUX_W-1:0]    r_mux_start;
    logic [C_MUX_W-1:0]    r_mux_end;

    logic                  r_phi1;
    logic                  r_prech;
    logic                  r_pixres;
    logic                  r_prechn_amp;
    logic                  r_frame_done;
    logic                  r_cfg_err;
    logic                  r_active;
    logic [15:0]           r_frame_cnt;

    logic                  w_cfg_ok;
    logic                  w_latch;
    logic                  w_done;
    logic                  w_err;
    logic                  w_flush;
    logic [C_ROW_W:0]      w_row_sum;
    logic                  w_dv;
    logic                  w_dl_nz;

    assign w_cfg_ok = cfg_ok(32'(ROW_START), 32'(ROW_END), 32'(ROW_STEP),
                             32'(MUX_START), 32'(MUX_END),
                             32'(C_NUM_ROWS), 32'(C_NUM_MUX));

    // One bit wider than the row address so a step past the last row never wraps.
    assign w_row_sum = {1'b0, r_row} + (C_ROW_W + 1)'(r_step);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_row_nxt   = r_row;
        w_mux_nxt   = r_mux;
        w_latch     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_flush     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    if (w_cfg_ok) begin
                        w_latch     = 1'b1;
                        w_row_nxt   = ROW_START;
                        w_state_nxt = ST_PH1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ST_PH1: begin
                if (r_cnt == C_PH1_LAST) begin
                    w_state_nxt = ST_PH2;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_PH2: begin
                if (r_cnt == C_PH2_LAST) begin
                    w_state_nxt = ST_MUX;
                    w_mux_nxt   = r_mux_start;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_MUX: begin
                if (r_mux == r_mux_end) begin
                    w_mux_nxt = C_MUX_PARK;
                    if (w_row_sum <= {1'b0, r_row_end}) begin
                        w_row_nxt   = w_row_sum[C_ROW_W-1:0];
                        w_state_nxt = ST_PH1;
                    end else begin
                        w_done = 1'b1;
                        if (CONTINUOUS && w_cfg_ok) begin
                            w_latch     = 1'b1;
                            w_row_nxt   = ROW_START;
                            w_state_nxt = ST_PH1;
                        end else begin
                            w_err       = CONTINUOUS;
                            w_row_nxt   = C_ROW_PARK;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else begin
                    w_mux_nxt = r_mux + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = C_ROW_PARK;
                w_mux_nxt   = C_MUX_PARK;
            end
        endcase

        // Abort overrides everything, including a coincident frame end.
        if (ABORT && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_row_nxt   = C_ROW_PARK;
            w_mux_nxt   = C_MUX_PARK;
            w_latch     = 1'b0;
            w_done      = 1'b0;
            w_err       = 1'b0;
            w_flush     = 1'b1;
        end
    end

    always_ff @(posedge ADC_PIXCLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_row        <= C_ROW_PARK;
            r_mux        <= C_MUX_PARK;
            r_row_end    <= '0;
            r_step       <= '0;
            r_mux_start  <= '0;
            r_mux_end    <= '0;
            r_phi1       <= 1'b0;
            r_prech      <= 1'b0;
            r_pixres     <= 1'b0;
            r_prechn_amp <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_active     <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_row        <= w_row_nxt;
            r_mux        <= w_mux_nxt;
            r_phi1       <= (w_state_nxt == ST_PH1);
            r_prech      <= (w_state_nxt == ST_PH1) && (w_cnt_nxt < C_PRECH_N);
            r_pixres     <= (w_state_nxt == ST_PH2);
            r_prechn_amp <= (w_state_nxt == ST_MUX);
            r_frame_done <= w_done;
            r_cfg_err    <= w_err;
            r_active     <= (w_state_nxt != ST_IDLE);
            if (w_latch) begin
                r_row_end   <= ROW_END;
                r_step      <= ROW_STEP;
                r_mux_start <= MUX_START;
                r_mux_end   <= MUX_END;
            end
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    roi_dv_delay #(
        .C_DEPTH (C_TLAT)
    ) u_dv_delay (
        .clk       (ADC_PIXCLK),
        .rst_n     (RESETN),
        .i_flush   (w_flush),
        .i_din     (r_prechn_amp),
        .o_dout    (w_dv),
        .o_nonzero (w_dl_nz)
    );

    assign PHI1       = r_phi1;
    assign PRECH_COL  = r_prech;
    assign PIXRES     = r_pixres;
    assign ROW_ADD    = r_row;
    assign MUX_ADD    = r_mux;
    assign PRECHN_AMP = r_prechn_amp;
    assign DATA_VALID = w_dv;
    assign BUSY       = r_active | w_dl_nz;
    assign FRAME_DONE = r_frame_done;
    assign CFG_ERR    = r_cfg_err;
    assign FRAME_CNT  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_roi_readout_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_roi_readout_seq
// Desc     : Self-checking bench for roi_readout_seq (C_TLAT=24 and C_TLAT=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_roi_readout_seq;

    localparam int NR = 160;
    localparam int NM = 46;
    localparam int P1 = 3;
    localparam int PR = 1;
    localparam int P2 = 2;
    localparam int TL = 24;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start_i, cont_i, abort_i;
    logic [7:0] rs, re;
    logic [3:0] st;
    logic [5:0] ms, me;

    logic        phi1, prech, pixres, amp, dv, busy, done, err;
    logic [7:0]  row_add;
    logic [5:0]  mux_add;
    logic [15:0] fcnt;
    logic        phi1_b, prech_b, pixres_b, amp_b, dv_b, busy_b, done_b, err_b;
    logic [7:0]  row_b;
    logic [5:0]  mux_b;
    logic [15:0] fcnt_b;

    always #5 clk = ~clk;

    roi_readout_seq #(.C_NUM_ROWS(NR), .C_NUM_MUX(NM), .C_ROW_W(8), .C_MUX_W(6),
                      .C_PHI1_CNT(P1), .C_PRECH_CNT(PR), .C_PHI2_CNT(P2), .C_TLAT(TL)) dut (
        .ADC_PIXCLK(clk), .RESETN(rstn), .START(start_i), .CONTINUOUS(cont_i), .ABORT(abort_i),
        .ROW_START(rs), .ROW_END(re), .ROW_STEP(st), .MUX_START(ms), .MUX_END(me),
        .PHI1(phi1), .PRECH_COL(prech), .PIXRES(pixres), .ROW_ADD(row_add), .MUX_ADD(mux_add),
        .PRECHN_AMP(amp), .DATA_VALID(dv), .BUSY(busy), .FRAME_DONE(done), .CFG_ERR(err),
        .FRAME_CNT(fcnt));

    roi_readout_seq #(.C_NUM_ROWS(NR), .C_NUM_MUX(NM), .C_ROW_W(8), .C_MUX_W(6),
                      .C_PHI1_CNT(P1), .C_PRECH_CNT(PR), .C_PHI2_CNT(P2), .C_TLAT(1)) dut_t1 (
        .ADC_PIXCLK(clk), .RESETN(rstn), .START(start_i), .CONTINUOUS(cont_i), .ABORT(abort_i),
        .ROW_START(rs), .ROW_END(re), .ROW_STEP(st), .MUX_START(ms), .MUX_END(me),
        .PHI1(phi1_b), .PRECH_COL(prech_b), .PIXRES(pixres_b), .ROW_ADD(row_b), .MUX_ADD(mux_b),
        .PRECHN_AMP(amp_b), .DATA_VALID(dv_b), .BUSY(busy_b), .FRAME_DONE(done_b), .CFG_ERR(err_b),
        .FRAME_CNT(fcnt_b));

    typedef struct {
        bit phi1; bit prech; bit pixres; bit amp;
        int row;  int mux;   bit done;   bit err;
    } cyc_t;

    typedef struct {
        int rs; int re; int st; int ms; int me;
        bit valid; int rows;
    } vec_t;

    cyc_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          chk_en = 0;
    bit          flush_pend = 0;
    logic [31:0] hist = '0;
    int          exp_cnt = 0;
    int          dv_cnt = 0, dv1_cnt = 0, phi_rises = 0, done_cnt = 0, err_cnt = 0;
    int          done_cyc = 0, t0 = 0;
    bit          prev_phi1 = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, expv);
        end
    endtask

    function automatic cyc_t idle_e(input bit d, input bit e);
        cyc_t c;
        c.phi1 = 0; c.prech = 0; c.pixres = 0; c.amp = 0;
        c.row = NR; c.mux = NM; c.done = d; c.err = e;
        return c;
    endfunction

    // Expected per-cycle trace of one frame; mux=-1 marks "address not checked".
    task automatic push_frame(input int rs_, input int re_, input int st_,
                              input int ms_, input int me_, input bit first_done);
        cyc_t c;
        bit   fd;
        fd = first_done;
        for (int r = rs_; r <= re_; r += st_) begin
            for (int i = 0; i < P1; i++) begin
                c = idle_e(fd, 0); c.phi1 = 1; c.prech = (i < PR); c.row = r; c.mux = -1;
                exp_q.push_back(c); fd = 0;
            end
            for (int i = 0; i < P2; i++) begin
                c = idle_e(0, 0); c.pixres = 1; c.row = r; c.mux = -1;
                exp_q.push_back(c);
            end
            for (int m = ms_; m <= me_; m++) begin
                c = idle_e(0, 0); c.amp = 1; c.row = r; c.mux = m;
                exp_q.push_back(c);
            end
        end
    endtask

    always @(negedge clk) begin : b_chk
        cyc_t e;
        logic act;
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = idle_e(0, 0);
            if (flush_pend) begin
                hist = '0;
                flush_pend = 0;
            end
            if (e.done) exp_cnt = (exp_cnt + 1) & 32'hFFFF;
            act = e.phi1 | e.pixres | e.amp;
            chk("PHI1",       32'(phi1),    32'(e.phi1));
            chk("PRECH_COL",  32'(prech),   32'(e.prech));
            chk("PIXRES",     32'(pixres),  32'(e.pixres));
            chk("PRECHN_AMP", 32'(amp),     32'(e.amp));
            chk("ROW_ADD",    32'(row_add), e.row);
            if (e.mux >= 0) chk("MUX_ADD", 32'(mux_add), e.mux);
            chk("FRAME_DONE", 32'(done),    32'(e.done));
            chk("CFG_ERR",    32'(err),     32'(e.err));
            chk("FRAME_CNT",  32'(fcnt),    exp_cnt);
            chk("DATA_VALID", 32'(dv),      32'(hist[TL-1]));
            chk("BUSY",       32'(busy),    32'(act | (|hist[TL-1:0])));
            chk("T1_STROBES", 32'({phi1_b, prech_b, pixres_b, amp_b, done_b, err_b}),
                              32'({e.phi1, e.prech, e.pixres, e.amp, e.done, e.err}));
            chk("T1_ROW_ADD", 32'(row_b),   e.row);
            if (e.mux >= 0) chk("T1_MUX_ADD", 32'(mux_b), e.mux);
            chk("T1_FRAME_CNT", 32'(fcnt_b), exp_cnt);
            chk("T1_DATA_VALID", 32'(dv_b), 32'(hist[0]));
            chk("T1_BUSY",    32'(busy_b),  32'(act | hist[0]));
            hist = {hist[30:0], e.amp};
            dv_cnt  += int'(dv);
            dv1_cnt += int'(dv_b);
            if (phi1 && !prev_phi1) phi_rises++;
            prev_phi1 = phi1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || hist[TL-1:0] != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL drain_timeout cyc=%0d got=%0d want=<%0d", cyc, n, budget);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic set_cfg(input int rs_, input int re_, input int st_, input int ms_, input int me_);
        rs = 8'(rs_); re = 8'(re_); st = 4'(st_); ms = 6'(ms_); me = 6'(me_);
    endtask

    // Called at negedge+1 of cycle n; START is visible to the DUT at the end of n.
    task automatic pulse_start(input bit cont);
        cont_i  = cont;
        start_i = 1'b1;
        t0      = cyc;
        @(negedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_strobes"}, 32'({phi1, prech, pixres, amp, dv, busy, done, err}), 32'd0);
        chk({tag, "_row"},     32'(row_add), NR);
        chk({tag, "_mux"},     32'(mux_add), NM);
        chk({tag, "_fcnt"},    32'(fcnt), 32'd0);
        chk({tag, "_t1"},      32'({phi1_b, amp_b, dv_b, busy_b, done_b, err_b}), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int dv0, dv10, ph0, er0, dn0, muxn;
        dv0 = dv_cnt; dv10 = dv1_cnt; ph0 = phi_rises; er0 = err_cnt; dn0 = done_cnt;
        muxn = v.me - v.ms + 1;
        if (v.valid) begin
            push_frame(v.rs, v.re, v.st, v.ms, v.me, 0);
            exp_q.push_back(idle_e(1, 0));
        end else begin
            exp_q.push_back(idle_e(0, 1));
        end
        set_cfg(v.rs, v.re, v.st, v.ms, v.me);
        pulse_start(0);
        rs = 8'($urandom); re = 8'($urandom); st = 4'($urandom);
        ms = 6'($urandom); me = 6'($urandom);
        drain(3000);
        if (v.valid) chk("latency", 32'(done_cyc - t0), 32'(v.rows * (P1 + P2 + muxn) + 1));
        chk("row_count",  32'(phi_rises - ph0), 32'(v.rows));
        chk("dv_count",   32'(dv_cnt - dv0),    32'(v.rows * (v.valid ? muxn : 0)));
        chk("dv1_count",  32'(dv1_cnt - dv10),  32'(v.rows * (v.valid ? muxn : 0)));
        chk("err_count",  32'(err_cnt - er0),   v.valid ? 32'd0 : 32'd1);
        chk("done_count", 32'(done_cnt - dn0),  v.valid ? 32'd1 : 32'd0);
    endtask

    vec_t vt[11];

    initial begin
        int dn0, er0, dv0, fc0;
        vt[0]  = '{rs:2,   re:5,   st:1,  ms:0,  me:3,  valid:1, rows:4};
        vt[1]  = '{rs:0,   re:9,   st:4,  ms:0,  me:1,  valid:1, rows:3};
        vt[2]  = '{rs:1,   re:1,   st:1,  ms:5,  me:5,  valid:1, rows:1};
        vt[3]  = '{rs:0,   re:160, st:1,  ms:0,  me:3,  valid:0, rows:0};
        vt[4]  = '{rs:0,   re:3,   st:1,  ms:3,  me:2,  valid:0, rows:0};
        vt[5]  = '{rs:0,   re:3,   st:0,  ms:0,  me:3,  valid:0, rows:0};
        vt[6]  = '{rs:150, re:159, st:15, ms:44, me:45, valid:1, rows:1};
        vt[7]  = '{rs:5,   re:4,   st:1,  ms:0,  me:0,  valid:0, rows:0};
        vt[8]  = '{rs:0,   re:0,   st:1,  ms:0,  me:46, valid:0, rows:0};
        vt[9]  = '{rs:159, re:159, st:1,  ms:45, me:45, valid:1, rows:1};
        vt[10] = '{rs:0,   re:5,   st:2,  ms:10, me:12, valid:1, rows:3};

        rstn = 1'b0; start_i = 0; cont_i = 0; abort_i = 0;
        set_cfg(0, 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        reset_checks("reset");
        rstn = 1'b1;
        chk_en = 1;
        @(negedge clk); #1;

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // Continuous: three back-to-back frames, then CONTINUOUS dropped.
        dn0 = done_cnt; dv0 = dv_cnt; fc0 = exp_cnt;
        push_frame(2, 3, 1, 0, 1, 0);
        push_frame(2, 3, 1, 0, 1, 1);
        push_frame(2, 3, 1, 0, 1, 1);
        exp_q.push_back(idle_e(1, 0));
        set_cfg(2, 3, 1, 0, 1);
        pulse_start(1);
        repeat (2 * 14 + 2) @(negedge clk);
        #1;
        cont_i = 0;
        drain(3000);
        chk("cont_done_count", 32'(done_cnt - dn0), 32'd3);
        chk("cont_last_done",  32'(done_cyc - t0),  32'(3 * 14 + 1));
        chk("cont_frame_cnt",  32'(fcnt),           32'(fc0 + 3));
        chk("cont_dv_count",   32'(dv_cnt - dv0),   32'(3 * 2 * 2));

        // Continuous re-latch sees an invalid config at frame end.
        dn0 = done_cnt; er0 = err_cnt;
        push_frame(2, 2, 1, 0, 1, 0);
        exp_q.push_back(idle_e(1, 1));
        set_cfg(2, 2, 1, 0, 1);
        pulse_start(1);
        ms = 6'd3; me = 6'd2;
        drain(3000);
        cont_i = 0;
        chk("relatch_err",  32'(err_cnt - er0),  32'd1);
        chk("relatch_done", 32'(done_cnt - dn0), 32'd1);

        // START held high restarts after each return to IDLE.
        dn0 = done_cnt;
        push_frame(1, 1, 1, 5, 5, 0);
        exp_q.push_back(idle_e(1, 0));
        push_frame(1, 1, 1, 5, 5, 0);
        exp_q.push_back(idle_e(1, 0));
        set_cfg(1, 1, 1, 5, 5);
        start_i = 1'b1;
        repeat (9) @(negedge clk);
        #1;
        start_i = 1'b0;
        drain(3000);
        chk("held_start_done", 32'(done_cnt - dn0), 32'd2);

        // ABORT mid-MUX of row 3.
        dn0 = done_cnt; fc0 = exp_cnt;
        push_frame(2, 5, 1, 0, 3, 0);
        set_cfg(2, 5, 1, 0, 3);
        pulse_start(0);
        repeat (15) @(negedge clk);
        #1;
        abort_i = 1'b1;
        exp_q.delete();
        flush_pend = 1;
        @(negedge clk); #1;
        abort_i = 1'b0;
        chk("abort_strobes", 32'({phi1, prech, pixres, amp, dv, busy}), 32'd0);
        chk("abort_row",     32'(row_add), NR);
        chk("abort_mux",     32'(mux_add), NM);
        chk("abort_fcnt",    32'(fcnt),    fc0);
        drain(3000);
        chk("abort_done",    32'(done_cnt - dn0), 32'd0);

        // ABORT while idle is ignored.
        abort_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        abort_i = 1'b0;
        run_vec(vt[2]);

        // Asynchronous reset in the middle of PH2.
        push_frame(2, 5, 1, 0, 3, 0);
        set_cfg(2, 5, 1, 0, 3);
        pulse_start(0);
        repeat (3) @(negedge clk);
        #1;
        chk_en = 0;
        #1;
        rstn = 1'b0;
        #1;
        reset_checks("midreset");
        exp_q.delete();
        hist = '0; flush_pend = 0; exp_cnt = 0; prev_phi1 = 0;
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
        chk_en = 1;
        @(negedge clk); #1;
        run_vec(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
